// File: rtl/mcu_encode_sched.sv
// rtl/mcu_encode_sched.sv - Y/Cb/Cr Huffman encoder sequencer and stream merger for one MCU row
//
// Walks the MCUs of one row. For each MCU it presents the column index, waits
// SETUP cycles, then issues one burst per component (Y, Cb, Cr). Every burst
// needs BURST words of downstream credit before it starts, and bursts are
// separated by a single idle cycle. A tag pipeline follows the requests through
// the encoder latency, so the matching encoder's output can be picked into one
// registered length/data stream.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   row_ready, h_mcu      start of a row and its MCU count (0 = empty row)
//   vsync                 frame boundary, abandons the current row
//   fifo_room             free words in the downstream packer FIFO
//   e_x_mcu, ereq         shared column index and one-hot encoder requests
//   elen_*, edata_*       per-encoder code length/data
//   out_len, out_data     merged stream (out_len == 0 means no word)
//   busy, row_done        row in progress / end-of-row pulse
//   overrun               sticky: row_ready seen while busy
module mcu_encode_sched #(
   parameter int DCT_TH  = 28,
   parameter int BURST   = DCT_TH + 1,
   parameter int SETUP   = 2,
   parameter int ENC_LAT = 5,
   parameter int ROOM_W  = 10
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              row_ready,
   input  logic [7:0]        h_mcu,
   input  logic              vsync,
   input  logic [ROOM_W-1:0] fifo_room,
   output logic [7:0]        e_x_mcu,
   output logic [2:0]        ereq,
   input  logic [5:0]        elen_y,
   input  logic [5:0]        elen_cb,
   input  logic [5:0]        elen_cr,
   input  logic [31:0]       edata_y,
   input  logic [31:0]       edata_cb,
   input  logic [31:0]       edata_cr,
   output logic [5:0]        out_len,
   output logic [31:0]       out_data,
   output logic              busy,
   output logic              row_done,
   output logic              overrun
);

   typedef enum logic [2:0] {
      S_IDLE, S_SETUP, S_WAIT_ROOM, S_BURST, S_GAP, S_DRAIN
   } state_t;

   state_t                   state_q;
   logic [6:0]               cnt_q;
   logic [1:0]               comp_q;
   logic [7:0]               h_q;
   logic [7:0]               e_x_mcu_q;
   logic [2:0]               ereq_q;
   logic [5:0]               out_len_q, out_len_d;
   logic [31:0]              out_data_q, out_data_d;
   logic                     busy_q, row_done_q, overrun_q;
   logic [ENC_LAT-1:0]       tag_v_q;
   logic [ENC_LAT-1:0][1:0]  tag_c_q;

   logic       check_now;
   logic [1:0] check_comp;
   logic [1:0] ereq_comp;
   logic       room_ok;
   logic       more_mcu;

   // CHECK is not a state: it is folded into the cycle that would leave
   // SETUP, WAIT_ROOM or GAP, so a granted burst follows without a bubble.
   always_comb begin
      check_now  = (state_q == S_SETUP && cnt_q == 7'(SETUP - 1)) ||
                   (state_q == S_WAIT_ROOM) ||
                   (state_q == S_GAP && comp_q != 2'd2);
      check_comp = (state_q == S_GAP) ? comp_q + 2'd1 : comp_q;
      room_ok    = fifo_room >= ROOM_W'(BURST);
      more_mcu   = ({1'b0, e_x_mcu_q} + 9'd1) < {1'b0, h_q};
      ereq_comp  = ereq_q[2] ? 2'd2 : (ereq_q[1] ? 2'd1 : 2'd0);
   end

   // Output of the tag pipeline lines up with the encoder's answer to the
   // request made ENC_LAT cycles earlier; untagged encoder data is dropped.
   always_comb begin
      out_len_d  = 6'd0;
      out_data_d = 32'd0;
      if (tag_v_q[ENC_LAT-1]) begin
         case (tag_c_q[ENC_LAT-1])
            2'd0:    begin out_len_d = elen_y;  out_data_d = edata_y;  end
            2'd1:    begin out_len_d = elen_cb; out_data_d = edata_cb; end
            default: begin out_len_d = elen_cr; out_data_d = edata_cr; end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         comp_q     <= '0;
         h_q        <= '0;
         e_x_mcu_q  <= '0;
         ereq_q     <= '0;
         out_len_q  <= '0;
         out_data_q <= '0;
         busy_q     <= 1'b0;
         row_done_q <= 1'b0;
         overrun_q  <= 1'b0;
         tag_v_q    <= '0;
         tag_c_q    <= '0;
      end else begin
         row_done_q <= 1'b0;
         if (row_ready && busy_q)
            overrun_q <= 1'b1;
         tag_v_q    <= {tag_v_q[ENC_LAT-2:0], |ereq_q};
         tag_c_q    <= {tag_c_q[ENC_LAT-2:0], ereq_comp};
         out_len_q  <= out_len_d;
         out_data_q <= out_data_d;

         if (vsync) begin
            // Abandon the row: requests in flight are forgotten, no row_done.
            state_q    <= S_IDLE;
            ereq_q     <= '0;
            busy_q     <= 1'b0;
            tag_v_q    <= '0;
            out_len_q  <= '0;
            out_data_q <= '0;
         end else begin
            case (state_q)
               S_IDLE: begin
                  if (row_ready) begin
                     h_q       <= h_mcu;
                     e_x_mcu_q <= 8'd0;
                     comp_q    <= 2'd0;
                     cnt_q     <= '0;
                     busy_q    <= 1'b1;
                     state_q   <= (h_mcu == 8'd0) ? S_DRAIN : S_SETUP;
                  end
               end
               S_SETUP: cnt_q <= cnt_q + 7'd1;
               S_BURST: begin
                  if (cnt_q == 7'(BURST - 1)) begin
                     ereq_q  <= '0;
                     state_q <= S_GAP;
                  end else begin
                     cnt_q <= cnt_q + 7'd1;
                  end
               end
               S_GAP: begin
                  if (comp_q == 2'd2) begin
                     cnt_q  <= '0;
                     comp_q <= 2'd0;
                     if (more_mcu) begin
                        e_x_mcu_q <= e_x_mcu_q + 8'd1;
                        state_q   <= S_SETUP;
                     end else begin
                        state_q <= S_DRAIN;
                     end
                  end
               end
               S_DRAIN: begin
                  // Last request's word leaves ENC_LAT+1 cycles after it;
                  // row_done marks the final drain cycle.
                  if (cnt_q == 7'(ENC_LAT - 1))
                     row_done_q <= 1'b1;
                  if (cnt_q == 7'(ENC_LAT)) begin
                     busy_q  <= 1'b0;
                     state_q <= S_IDLE;
                  end else begin
                     cnt_q <= cnt_q + 7'd1;
                  end
               end
               default: state_q <= S_IDLE;
            endcase

            // One burst per grant; fifo_room is only looked at here.
            if (check_now) begin
               comp_q <= check_comp;
               if (room_ok) begin
                  state_q <= S_BURST;
                  ereq_q  <= 3'b001 << check_comp;
                  cnt_q   <= '0;
               end else begin
                  state_q <= S_WAIT_ROOM;
               end
            end
         end
      end
   end

   assign e_x_mcu  = e_x_mcu_q;
   assign ereq     = ereq_q;
   assign out_len  = out_len_q;
   assign out_data = out_data_q;
   assign busy     = busy_q;
   assign row_done = row_done_q;
   assign overrun  = overrun_q;

endmodule
